// File: rtl/spi_master_pkg.sv
// Shared definitions for the SPI frame master: FSM states, SPI mode and
// per-byte edge count.
package spi_master_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_BYTE,
    SHIFT,
    TRAIL,
    DONE
  } state_t;

  typedef struct packed {
    logic cpol;
    logic cpha;
  } spi_mode_t;

  localparam spi_mode_t SPI_MODE0 = '{cpol: 1'b0, cpha: 1'b0};

  // 8 rising plus 8 falling SCK edges per byte
  localparam int BYTE_EDGES = 16;

endpackage

// File: rtl/spi_frame_master_sck_gen.sv
// SCK divider: toggles SCK every CLK_DIV enabled cycles and flags the
// clk cycle on which the next toggle will be a rising or falling edge.
module spi_sck_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic sck,
  output logic rise,
  output logic fall
);
  import spi_master_pkg::*;

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] div_cnt;
  logic          wrap;

  // Strobes are asserted in the cycle before SCK actually changes, so the
  // owner can act on the same clk edge that moves SCK.
  assign wrap = en && !clr && (div_cnt == DIV_LAST);
  assign rise = wrap && (sck == SPI_MODE0.cpol);
  assign fall = wrap && (sck != SPI_MODE0.cpol);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      div_cnt <= '0;
      sck     <= SPI_MODE0.cpol;
    end else if (en) begin
      if (wrap) begin
        div_cnt <= '0;
        sck     <= ~sck;
      end else begin
        div_cnt <= div_cnt + DW'(1);
      end
    end
  end

endmodule

// File: rtl/spi_frame_master.sv
// SPI mode-0 frame master: streams FRAME_BYTES bytes MSB first under one
// SS-low window and returns each byte captured on MISO.
module spi_frame_master #(
  parameter int CLK_DIV      = 4,
  parameter int FRAME_BYTES  = 785,
  parameter int TRAIL_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       busy,
  output logic       done,
  output logic       SCK,
  output logic       SS,
  output logic       MOSI,
  input  logic       MISO
);
  import spi_master_pkg::*;

  localparam int BCW = $clog2(FRAME_BYTES + 1);
  localparam logic [BCW-1:0] LAST_BYTE = BCW'(FRAME_BYTES - 1);
  localparam int TCW = (TRAIL_CYCLES > 2) ? $clog2(TRAIL_CYCLES) : 1;
  localparam logic [TCW-1:0] TRAIL_LAST = TCW'((TRAIL_CYCLES > 2) ? TRAIL_CYCLES - 2 : 0);
  localparam logic [4:0] EDGES_DONE = 5'(BYTE_EDGES);
  localparam logic [4:0] LAST_FALL  = 5'(BYTE_EDGES - 1);

  state_t         state;
  logic [BCW-1:0] byte_cnt;
  logic [4:0]     edge_cnt;
  logic [TCW-1:0] trail_cnt;
  logic [7:0]     tx_sr;
  logic [7:0]     rx_sr;
  logic           tx_ready_q;
  logic           aborting;
  logic           handshake;
  logic           sck_en;
  logic           sck_clr;
  logic           sck_rise;
  logic           sck_fall;

  // An abort must refuse a byte offered in the same cycle, so the registered
  // ready is masked rather than waiting a cycle to drop.
  assign aborting  = abort && (state != IDLE);
  assign tx_ready  = tx_ready_q && !aborting;
  assign handshake = tx_valid && tx_ready;
  assign sck_en    = (state == SHIFT) && (edge_cnt != EDGES_DONE);
  assign sck_clr   = (state != SHIFT) || aborting;

  spi_sck_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_sck_gen (
    .clk  (clk),
    .rst  (rst),
    .en   (sck_en),
    .clr  (sck_clr),
    .sck  (SCK),
    .rise (sck_rise),
    .fall (sck_fall)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      SS         <= 1'b1;
      MOSI       <= 1'b0;
      tx_ready_q <= 1'b0;
      rx_valid   <= 1'b0;
      rx_data    <= 8'h00;
      busy       <= 1'b0;
      done       <= 1'b0;
      byte_cnt   <= '0;
      edge_cnt   <= '0;
      trail_cnt  <= '0;
    end else begin
      rx_valid <= 1'b0;
      done     <= 1'b0;
      if (aborting) begin
        state      <= IDLE;
        SS         <= 1'b1;
        MOSI       <= 1'b0;
        tx_ready_q <= 1'b0;
        busy       <= 1'b0;
        byte_cnt   <= '0;
        edge_cnt   <= '0;
        trail_cnt  <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              state      <= WAIT_BYTE;
              SS         <= 1'b0;
              busy       <= 1'b1;
              byte_cnt   <= '0;
              tx_ready_q <= 1'b1;
            end
          end
          WAIT_BYTE: begin
            if (handshake) begin
              tx_ready_q <= 1'b0;
              tx_sr      <= tx_data;
              MOSI       <= tx_data[7];
              edge_cnt   <= '0;
              state      <= SHIFT;
            end
          end
          SHIFT: begin
            if (sck_rise) begin
              rx_sr    <= {rx_sr[6:0], MISO};
              edge_cnt <= edge_cnt + 5'd1;
            end else if (sck_fall) begin
              edge_cnt <= edge_cnt + 5'd1;
              // MOSI keeps bit 0 after the final falling edge
              if (edge_cnt != LAST_FALL) begin
                tx_sr <= {tx_sr[6:0], 1'b0};
                MOSI  <= tx_sr[6];
              end
            end else if (edge_cnt == EDGES_DONE) begin
              rx_data  <= rx_sr;
              rx_valid <= 1'b1;
              byte_cnt <= byte_cnt + BCW'(1);
              if (byte_cnt == LAST_BYTE) begin
                if (TRAIL_CYCLES > 1) begin
                  state     <= TRAIL;
                  trail_cnt <= '0;
                end else begin
                  state <= DONE;
                  SS    <= 1'b1;
                  done  <= 1'b1;
                end
              end else begin
                state      <= WAIT_BYTE;
                tx_ready_q <= 1'b1;
              end
            end
          end
          TRAIL: begin
            // The cycle after the last falling edge already counts as trail.
            if (trail_cnt == TRAIL_LAST) begin
              state <= DONE;
              SS    <= 1'b1;
              done  <= 1'b1;
            end else begin
              trail_cnt <= trail_cnt + TCW'(1);
            end
          end
          DONE: begin
            busy  <= 1'b0;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_frame_master.sv
// Directed bench for spi_frame_master: three instances cover single-byte
// loopback, a gapped three-byte frame with abort, and a full 785-byte frame.
module tb_spi_frame_master;

  localparam int TRAIL = 4;
  localparam int FB_C  = 785;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  logic       start_a, abort_a, tx_valid_a, tx_ready_a, rx_valid_a, busy_a, done_a, SCK_a, SS_a, MOSI_a;
  logic [7:0] tx_data_a, rx_data_a;
  logic       start_b, abort_b, tx_valid_b, tx_ready_b, rx_valid_b, busy_b, done_b, SCK_b, SS_b, MOSI_b, MISO_b;
  logic [7:0] tx_data_b, rx_data_b;
  logic       start_c, abort_c, tx_valid_c, tx_ready_c, rx_valid_c, busy_c, done_c, SCK_c, SS_c, MOSI_c;
  logic [7:0] tx_data_c, rx_data_c;

  spi_frame_master #(.CLK_DIV(4), .FRAME_BYTES(1), .TRAIL_CYCLES(TRAIL)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .abort(abort_a), .tx_data(tx_data_a),
    .tx_valid(tx_valid_a), .tx_ready(tx_ready_a), .rx_data(rx_data_a), .rx_valid(rx_valid_a),
    .busy(busy_a), .done(done_a), .SCK(SCK_a), .SS(SS_a), .MOSI(MOSI_a), .MISO(MOSI_a));

  spi_frame_master #(.CLK_DIV(4), .FRAME_BYTES(3), .TRAIL_CYCLES(TRAIL)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .abort(abort_b), .tx_data(tx_data_b),
    .tx_valid(tx_valid_b), .tx_ready(tx_ready_b), .rx_data(rx_data_b), .rx_valid(rx_valid_b),
    .busy(busy_b), .done(done_b), .SCK(SCK_b), .SS(SS_b), .MOSI(MOSI_b), .MISO(MISO_b));

  spi_frame_master #(.CLK_DIV(2), .FRAME_BYTES(FB_C), .TRAIL_CYCLES(TRAIL)) dut_c (
    .clk(clk), .rst(rst), .start(start_c), .abort(abort_c), .tx_data(tx_data_c),
    .tx_valid(tx_valid_c), .tx_ready(tx_ready_c), .rx_data(rx_data_c), .rx_valid(rx_valid_c),
    .busy(busy_c), .done(done_c), .SCK(SCK_c), .SS(SS_c), .MOSI(MOSI_c), .MISO(MOSI_c));

  // Mode-0 slave for dut_b: presents 8'h07 MSB first, advances on SCK falls.
  logic [7:0] slave_sr;
  always @(negedge SCK_b or posedge SS_b) begin
    if (SS_b) slave_sr <= 8'h07;
    else      slave_sr <= {slave_sr[6:0], slave_sr[7]};
  end
  assign MISO_b = slave_sr[7];

  int cyc = 0;
  logic sck_prev_a = 1'b0;
  int rise_cnt_a = 0, hi_run_a = 0, hi_len_a = 0, fall_cyc_a = 0, done_cyc_a = 0;
  int done_cnt_a = 0, rxv_cnt_a = 0;
  logic [7:0] mosi_bits_a = 8'h00;
  always @(negedge clk) begin
    cyc        <= cyc + 1;
    sck_prev_a <= SCK_a;
    if (SCK_a && !sck_prev_a) begin
      rise_cnt_a  <= rise_cnt_a + 1;
      mosi_bits_a <= {mosi_bits_a[6:0], MOSI_a};
    end
    if (SCK_a) hi_run_a <= hi_run_a + 1;
    else if (sck_prev_a) begin
      hi_len_a   <= hi_run_a;
      hi_run_a   <= 0;
      fall_cyc_a <= cyc;
    end
    if (done_a) begin
      done_cnt_a <= done_cnt_a + 1;
      done_cyc_a <= cyc;
    end
    if (rx_valid_a) rxv_cnt_a <= rxv_cnt_a + 1;
  end

  logic sck_prev_b = 1'b0, ss_prev_b = 1'b1;
  int rise_cnt_b = 0, rxv_cnt_b = 0, rx_bad_b = 0, done_cnt_b = 0;
  int gap_sck_b = 0, gap_cyc_b = 0, ss_viol_b = 0, ss_fall_b = 0;
  always @(negedge clk) begin
    sck_prev_b <= SCK_b;
    ss_prev_b  <= SS_b;
    if (SCK_b && !sck_prev_b) rise_cnt_b <= rise_cnt_b + 1;
    if (!SS_b && ss_prev_b) ss_fall_b <= ss_fall_b + 1;
    if (rx_valid_b) begin
      rxv_cnt_b <= rxv_cnt_b + 1;
      if (rx_data_b !== 8'h07) rx_bad_b <= rx_bad_b + 1;
    end
    if (done_b) done_cnt_b <= done_cnt_b + 1;
    if (tx_ready_b && !tx_valid_b) gap_cyc_b <= gap_cyc_b + 1;
    if (tx_ready_b && SCK_b) gap_sck_b <= gap_sck_b + 1;
    if (busy_b && SS_b && !done_b) ss_viol_b <= ss_viol_b + 1;
  end

  logic [7:0] exp_c [FB_C];
  int rx_idx_c = 0, rx_bad_c = 0, ss_low_c = 0, done_cnt_c = 0;
  always @(negedge clk) begin
    if (!SS_c) ss_low_c <= ss_low_c + 1;
    if (done_c) done_cnt_c <= done_cnt_c + 1;
    if (rx_valid_c) begin
      rx_idx_c <= rx_idx_c + 1;
      if (rx_idx_c >= FB_C) rx_bad_c <= rx_bad_c + 1;
      else if (rx_data_c !== exp_c[rx_idx_c]) rx_bad_c <= rx_bad_c + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [7:0] pat_b [3];
  int base_rise, base_rx, base_done, base_ss;

  initial begin
    rst = 1'b1;
    start_a = 0; abort_a = 0; tx_valid_a = 0; tx_data_a = 8'h00;
    start_b = 0; abort_b = 0; tx_valid_b = 0; tx_data_b = 8'h00;
    start_c = 0; abort_c = 0; tx_valid_c = 0; tx_data_c = 8'h00;
    pat_b[0] = 8'h01; pat_b[1] = 8'h80; pat_b[2] = 8'hFF;
    repeat (3) @(negedge clk);

    // reset values
    chk("rst_sck", SCK_a, 0);      chk("rst_ss", SS_a, 1);      chk("rst_mosi", MOSI_a, 0);
    chk("rst_ready", tx_ready_a, 0); chk("rst_rxv", rx_valid_a, 0); chk("rst_rxd", rx_data_a, 0);
    chk("rst_busy", busy_a, 0);    chk("rst_done", done_a, 0);
    chk("rst_ss_b", SS_b, 1);      chk("rst_ss_c", SS_c, 1);
    rst = 1'b0;

    // single byte A5 with loopback
    tx_data_a = 8'hA5; tx_valid_a = 1'b1;
    start_a = 1'b1; @(negedge clk); start_a = 1'b0;
    chk("a_ss_low", SS_a, 0); chk("a_busy", busy_a, 1); chk("a_ready", tx_ready_a, 1);
    for (int i = 0; i < 400 && !done_a; i++) @(negedge clk);
    chk("a_done_seen", done_a, 1);
    chk("a_ss_at_done", SS_a, 1);
    @(negedge clk);
    chk("a_busy_after_done", busy_a, 0);
    chk("a_done_one_cycle", done_a, 0);
    chk("a_mosi_order", mosi_bits_a, 8'hA5);
    chk("a_rise_count", rise_cnt_a, 8);
    chk("a_sck_high_len", hi_len_a, 4);
    chk("a_fall_to_done", done_cyc_a - fall_cyc_a, TRAIL);
    chk("a_rx_count", rxv_cnt_a, 1);
    chk("a_rx_data", rx_data_a, 8'hA5);
    chk("a_done_count", done_cnt_a, 1);

    // reset in the middle of SHIFT
    start_a = 1'b1; @(negedge clk); start_a = 1'b0;
    for (int i = 0; i < 400 && rise_cnt_a < 11; i++) @(negedge clk);
    chk("a_mid_shift_busy", busy_a, 1);
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    chk("a_mrst_sck", SCK_a, 0);   chk("a_mrst_ss", SS_a, 1);      chk("a_mrst_mosi", MOSI_a, 0);
    chk("a_mrst_ready", tx_ready_a, 0); chk("a_mrst_busy", busy_a, 0); chk("a_mrst_rxd", rx_data_a, 0);
    chk("a_mrst_rxv", rx_valid_a, 0); chk("a_mrst_done", done_a, 0);

    // start while in TRAIL must not launch a second frame
    base_done = done_cnt_a;
    start_a = 1'b1; @(negedge clk); start_a = 1'b0;
    for (int i = 0; i < 400 && !rx_valid_a; i++) @(negedge clk);
    chk("a_rxv_before_trail", rx_valid_a, 1);
    start_a = 1'b1; @(negedge clk); start_a = 1'b0;
    repeat (150) @(negedge clk);
    chk("a_trail_start_done_cnt", done_cnt_a - base_done, 1);
    chk("a_trail_start_busy", busy_a, 0);
    chk("a_trail_start_ss", SS_a, 1);

    // three bytes with 10-cycle valid gaps, slave returns 07
    start_b = 1'b1; @(negedge clk); start_b = 1'b0;
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 400 && !tx_ready_b; i++) @(negedge clk);
      repeat (10) @(negedge clk);
      tx_data_b = pat_b[k]; tx_valid_b = 1'b1;
      @(negedge clk); tx_valid_b = 1'b0;
    end
    for (int i = 0; i < 400 && !done_b; i++) @(negedge clk);
    chk("b_done_seen", done_b, 1);
    @(negedge clk);
    chk("b_rx_count", rxv_cnt_b, 3);
    chk("b_done_count", done_cnt_b, 1);
    chk("b_rx_data_07", rx_bad_b, 0);
    chk("b_last_rx", rx_data_b, 8'h07);
    chk("b_sck_in_gap", gap_sck_b, 0);
    chk("b_gap_seen", gap_cyc_b >= 30, 1);
    chk("b_ss_held", ss_viol_b, 0);
    chk("b_ss_falls", ss_fall_b, 1);

    // abort against a simultaneous handshake
    start_b = 1'b1; @(negedge clk); start_b = 1'b0;
    tx_data_b = 8'h5A; tx_valid_b = 1'b1; abort_b = 1'b1;
    #1;
    chk("b_abort_masks_ready", tx_ready_b, 0);
    base_rise = rise_cnt_b;
    @(negedge clk); abort_b = 1'b0; tx_valid_b = 1'b0;
    chk("b_abort_hs_ss", SS_b, 1);
    chk("b_abort_hs_busy", busy_b, 0);
    repeat (30) @(negedge clk);
    chk("b_abort_hs_no_shift", rise_cnt_b - base_rise, 0);

    // abort on the 5th rising edge of byte 2
    base_rise = rise_cnt_b; base_rx = rxv_cnt_b; base_done = done_cnt_b;
    tx_data_b = 8'h3C; tx_valid_b = 1'b1;
    start_b = 1'b1; @(negedge clk); start_b = 1'b0;
    for (int i = 0; i < 1000 && (rise_cnt_b - base_rise) < 13; i++) @(negedge clk);
    chk("b_reach_rise13", rise_cnt_b - base_rise, 13);
    chk("b_sck_high_at_abort", SCK_b, 1);
    abort_b = 1'b1; @(negedge clk); abort_b = 1'b0;
    chk("b_abort_ss", SS_b, 1);   chk("b_abort_sck", SCK_b, 0);
    chk("b_abort_busy", busy_b, 0); chk("b_abort_mosi", MOSI_b, 0);
    repeat (200) @(negedge clk);
    chk("b_abort_rx_count", rxv_cnt_b - base_rx, 1);
    chk("b_abort_no_done", done_cnt_b - base_done, 0);

    // clean frame after abort
    base_rx = rxv_cnt_b; base_done = done_cnt_b;
    start_b = 1'b1; @(negedge clk); start_b = 1'b0;
    for (int i = 0; i < 1000 && !done_b; i++) @(negedge clk);
    chk("b_clean_done_seen", done_b, 1);
    @(negedge clk); tx_valid_b = 1'b0;
    chk("b_clean_rx_count", rxv_cnt_b - base_rx, 3);
    chk("b_clean_done_count", done_cnt_b - base_done, 1);
    chk("b_clean_rx_data", rx_bad_b, 0);

    // full frame, CLK_DIV=2, random bytes, loopback
    for (int k = 0; k < FB_C; k++) exp_c[k] = 8'($urandom);
    base_ss = ss_low_c;
    tx_data_c = exp_c[0]; tx_valid_c = 1'b1;
    start_c = 1'b1; @(negedge clk); start_c = 1'b0;
    for (int k = 0; k < FB_C; k++) begin
      tx_data_c = exp_c[k];
      for (int i = 0; i < 200 && !tx_ready_c; i++) @(negedge clk);
      @(negedge clk);
    end
    tx_valid_c = 1'b0;
    for (int i = 0; i < 200 && !done_c; i++) @(negedge clk);
    chk("c_done_seen", done_c, 1);
    @(negedge clk);
    chk("c_rx_count", rx_idx_c, FB_C);
    chk("c_rx_match", rx_bad_c, 0);
    chk("c_done_count", done_cnt_c, 1);
    // 32 SCK cycles + ready cycle + rx_valid cycle per byte; the rx_valid
    // cycle of the last byte is also the first trail cycle.
    chk("c_ss_low_span", ss_low_c - base_ss, FB_C * 34 + TRAIL - 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
